vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-clock divider, h/v counters and registered sync/blank decode.
// Optional frame counter is built when VGA_TIMING_FRAME_CNT_EN is defined; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIX_DIV  = 1,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int FRAME_W  = 8
) (
    input  logic               clock,
    input  logic               rst_n,
    output logic               pix_en,
    output logic               hs,
    output logic               vs,
    output logic               active,
    output logic               hblank,
    output logic               vblank,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]   H_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0]   HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0]   VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             HS_ON    = (HS_POL != 0);
    localparam logic             VS_ON    = (VS_POL != 0);

    // Back porches must be non-empty so the reset position decodes as blanking.
    if (H_BP == 0 || V_BP == 0 || H_SYNC == 0 || V_SYNC == 0 || PIX_DIV == 0) begin : g_bad_segment
        $error("vga_timing_gen: H_BP, V_BP, H_SYNC, V_SYNC and PIX_DIV must all be non-zero");
    end
    if (longint'(H_TOTAL) > (64'd1 << X_W) || longint'(V_TOTAL) > (64'd1 << Y_W)) begin : g_bad_width
        $error("vga_timing_gen: counter width too small for H_TOTAL/V_TOTAL");
    end

    logic [DIV_W-1:0] r_div;
    logic [X_W-1:0]   r_hcount;
    logic [Y_W-1:0]   r_vcount;
    logic             r_pix_en;
    logic             r_hs;
    logic             r_vs;
    logic             r_active;
    logic             r_hblank;
    logic             r_vblank;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic             r_line_start;
    logic             r_frame_start;

    logic             w_tick;
    logic             w_h_wrap;
    logic [X_W-1:0]   w_h_next;
    logic [Y_W-1:0]   w_v_next;
    logic             w_h_act;
    logic             w_v_act;
    logic             w_hs_on;
    logic             w_vs_on;
    logic             w_line_start;
    logic             w_frame_start;

    // Decode operates on the position the counters are about to take, so outputs share the counter edge.
    always_comb begin
        w_tick        = (r_div == DIV_LAST);
        w_h_wrap      = (r_hcount == H_LAST);
        w_h_next      = w_h_wrap ? '0 : r_hcount + 1'b1;
        w_v_next      = r_vcount;
        if (w_h_wrap) begin
            w_v_next  = (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
        end
        w_h_act       = (w_h_next < H_ACT);
        w_v_act       = (w_v_next < V_ACT);
        w_hs_on       = (w_h_next >= HS_START) && (w_h_next < HS_END);
        w_vs_on       = (w_v_next >= VS_START) && (w_v_next < VS_END);
        w_line_start  = w_tick && (w_h_next == '0);
        w_frame_start = w_line_start && (w_v_next == '0);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_hcount      <= H_LAST;
            r_vcount      <= V_LAST;
            r_pix_en      <= 1'b0;
            r_hs          <= ~HS_ON;
            r_vs          <= ~VS_ON;
            r_active      <= 1'b0;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_tick ? '0 : r_div + 1'b1;
            r_pix_en      <= w_tick;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
            if (w_tick) begin
                r_hcount  <= w_h_next;
                r_vcount  <= w_v_next;
                r_hs      <= w_hs_on ? HS_ON : ~HS_ON;
                r_vs      <= w_vs_on ? VS_ON : ~VS_ON;
                r_active  <= w_h_act && w_v_act;
                r_hblank  <= !w_h_act;
                r_vblank  <= !w_v_act;
                r_x       <= (w_h_act && w_v_act) ? w_h_next : '0;
                r_y       <= (w_h_act && w_v_act) ? w_v_next : '0;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_W-1:0] r_frame_cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_frame_start) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

    assign pix_en      = r_pix_en;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign active      = r_active;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
